id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-delivery stage. It sits directly upstream of the ALU and drives its aluop, opr_a and opr_b inputs.
- Registers decoded fields from ID, resolves EX operands with MEM/WB forwarding, detects load-use hazards and inserts bubbles.
- Honours stall and flush requests from the hazard/CSR trap logic.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- id_valid  in  1  ID holds a valid instruction.
- id_pc  in  XLEN  instruction PC.
- id_rs1_addr, id_rs2_addr, id_rd_addr  in  RA_W  register addresses.
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_aluop  in  4  ALU opcode.
- id_sel_a  in  1  0 = rs1, 1 = pc.
- id_sel_b  in  1  0 = rs2, 1 = imm.
- id_uses_rs2  in  1  instruction reads rs2.
- id_wb_en, id_mem_rd, id_mem_wr  in  1  control.
- stall  in  1  hold EX contents.
- flush  in  1  kill EX contents (branch/trap).
- mem_fwd_en  in  1  MEM-stage write pending.
- mem_fwd_rd  in  RA_W  MEM-stage destination.
- mem_fwd_data  in  XLEN  MEM-stage result.
- wb_fwd_en  in  1  WB-stage write pending.
- wb_fwd_rd  in  RA_W  WB-stage destination.
- wb_fwd_data  in  XLEN  WB-stage result.
- load_use_hazard  out  1  ID must hold this cycle (combinational).
- ex_valid  out  1  EX holds a valid instruction.
- ex_aluop  out  4  to ALU aluop.
- ex_opr_a, ex_opr_b  out  XLEN  to ALU operands (forwarded, post-select).
- ex_store_data  out  XLEN  forwarded rs2 for stores.
- ex_pc  out  XLEN  registered PC.
- ex_rd_addr  out  RA_W  destination register.
- ex_wb_en, ex_mem_rd, ex_mem_wr  out  1  control, forced to 0 when ex_valid = 0.

Behaviour:
- Reset: all registered state is 0. ex_valid = 0, ex_aluop = 4'b0000, all data and control outputs are 0.
- Register update priority at each posedge: flush > stall > load_use_hazard > load.
  - flush: ex_valid <= 0; control bits <= 0; aluop <= ADD.
  - stall: fields held. rs1/rs2 data registers reload their own forwarded value, so a WB retiring during the stall is not lost.
  - hazard: bubble inserted (same as flush); ID is expected to re-present the same instruction.
  - else: all fields loaded from id_*; ex_valid <= id_valid.
- load_use_hazard = ex_valid & ex_mem_rd & (ex_rd_addr != 0) & id_valid & ((id_rs1_addr == ex_rd_addr) | (id_uses_rs2 & (id_rs2_addr == ex_rd_addr))).
  - Asserted regardless of stall or flush; the consumer gates it.
- Forwarding, per operand, combinational on the registered rs address/data:
  - MEM match (en & rd == addr & addr != 0) wins.
  - Else WB match.
  - Else registered data.
  - x0 is never forwarded; it reads the registered value, which the register file provides as 0.
- ex_opr_a = sel_a ? pc : fwd_rs1. ex_opr_b = sel_b ? imm : fwd_rs2. ex_store_data = fwd_rs2 always.
- Latency: one cycle from ID to EX register. Operand outputs are valid in the same cycle as the forwarding inputs.
- Reset asserted mid-operation clears state immediately, without waiting for a clock edge.
- No arithmetic is performed; all widths pass through unchanged.

Decomposition:
- Shared package riscv_pkg holds:
  - ALU opcode constants: ADD 0000, SUB 1000, SLL 0001, SLT 0010, SLTU 0011, XOR 0100, SRL 0101, SRA 1101, OR 0110, AND 0111, PASS 1111.
  - fwd_sel_e enum: FWD_NONE, FWD_MEM, FWD_WB.
  - ex_ctrl_t struct bundling wb_en, mem_rd, mem_wr, aluop, sel_a, sel_b.
- One combinational sub-module, operand_fwd (address, data, both forward sources → value), instantiated twice.

Test Plan:
- Reset → ex_valid = 0, ex_aluop = 0000, ex_opr_a = ex_opr_b = 0.
- Load: ID add x3,x1,x2 with rs1_data = 5, rs2_data = 7, no forwarding → next cycle ex_opr_a = 5, ex_opr_b = 7, ex_aluop = 0000, ex_valid = 1.
- Forwarding: EX holds rs1 = x4. Both mem_fwd (rd x4, data 0xAA) and wb_fwd (rd x4, data 0xBB) asserted → ex_opr_a = 0xAA. With rd = x0 on both and registered data 0 → ex_opr_a = 0.
- Load-use: EX has lw x5 and ID reads x5 → load_use_hazard = 1; next cycle ex_valid = 0 and ex_mem_rd = 0. With id_rs2_addr = x5 but id_uses_rs2 = 0 → no hazard.
- Stall refresh: stall = 1 for 2 cycles while wb_fwd writes rs1 (x6 = 0x1234) in cycle 1 → after stall release ex_opr_a = 0x1234, other fields unchanged.
- Flush wins: flush and stall asserted together → next cycle ex_valid = 0, ex_wb_en = 0. Reset pulse between clock edges → outputs 0 immediately.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V pipeline definitions: ALU opcodes, forwarding select and the
// control bundle carried through the ID/EX register.
package riscv_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b1000;
  localparam logic [3:0] ALU_SLL  = 4'b0001;
  localparam logic [3:0] ALU_SLT  = 4'b0010;
  localparam logic [3:0] ALU_SLTU = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SRL  = 4'b0101;
  localparam logic [3:0] ALU_SRA  = 4'b1101;
  localparam logic [3:0] ALU_OR   = 4'b0110;
  localparam logic [3:0] ALU_AND  = 4'b0111;
  localparam logic [3:0] ALU_PASS = 4'b1111;

  typedef enum logic [1:0] {
    FWD_NONE,
    FWD_MEM,
    FWD_WB
  } fwd_sel_e;

  typedef struct packed {
    logic       wb_en;
    logic       mem_rd;
    logic       mem_wr;
    logic [3:0] aluop;
    logic       sel_a;
    logic       sel_b;
  } ex_ctrl_t;

  // A bubble is an ADD with no side effects.
  localparam ex_ctrl_t CTRL_BUBBLE = '{
    wb_en:  1'b0,
    mem_rd: 1'b0,
    mem_wr: 1'b0,
    aluop:  ALU_ADD,
    sel_a:  1'b0,
    sel_b:  1'b0
  };

endpackage

// File: rtl/operand_fwd.sv
// Single-operand bypass mux: MEM result beats WB result beats the registered
// read data; x0 always keeps the registered value.
module operand_fwd
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic [RA_W-1:0] addr,
  input  logic [XLEN-1:0] reg_data,
  input  logic            mem_en,
  input  logic [RA_W-1:0] mem_rd,
  input  logic [XLEN-1:0] mem_data,
  input  logic            wb_en,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic [XLEN-1:0] value
);

  fwd_sel_e sel;

  always_comb begin
    sel = FWD_NONE;
    if (addr != '0) begin
      if (mem_en && (mem_rd == addr)) begin
        sel = FWD_MEM;
      end else if (wb_en && (wb_rd == addr)) begin
        sel = FWD_WB;
      end
    end
  end

  always_comb begin
    value = reg_data;
    case (sel)
      FWD_MEM: value = mem_data;
      FWD_WB:  value = wb_data;
      default: value = reg_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with MEM/WB operand forwarding, load-use bubble
// insertion and stall/flush handling; feeds the ALU directly.
module id_ex_stage
  import riscv_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int RA_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc,
  input  logic [RA_W-1:0] id_rs1_addr,
  input  logic [RA_W-1:0] id_rs2_addr,
  input  logic [RA_W-1:0] id_rd_addr,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [3:0]      id_aluop,
  input  logic            id_sel_a,
  input  logic            id_sel_b,
  input  logic            id_uses_rs2,
  input  logic            id_wb_en,
  input  logic            id_mem_rd,
  input  logic            id_mem_wr,
  input  logic            stall,
  input  logic            flush,
  input  logic            mem_fwd_en,
  input  logic [RA_W-1:0] mem_fwd_rd,
  input  logic [XLEN-1:0] mem_fwd_data,
  input  logic            wb_fwd_en,
  input  logic [RA_W-1:0] wb_fwd_rd,
  input  logic [XLEN-1:0] wb_fwd_data,
  output logic            load_use_hazard,
  output logic            ex_valid,
  output logic [3:0]      ex_aluop,
  output logic [XLEN-1:0] ex_opr_a,
  output logic [XLEN-1:0] ex_opr_b,
  output logic [XLEN-1:0] ex_store_data,
  output logic [XLEN-1:0] ex_pc,
  output logic [RA_W-1:0] ex_rd_addr,
  output logic            ex_wb_en,
  output logic            ex_mem_rd,
  output logic            ex_mem_wr
);

  logic            vld_p0;
  ex_ctrl_t        ctrl_p0;
  logic [XLEN-1:0] pc_p0;
  logic [XLEN-1:0] imm_p0;
  logic [RA_W-1:0] rs1_addr_p0;
  logic [RA_W-1:0] rs2_addr_p0;
  logic [RA_W-1:0] rd_addr_p0;
  logic [XLEN-1:0] rs1_data_p0;
  logic [XLEN-1:0] rs2_data_p0;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;
  ex_ctrl_t        id_ctrl;

  assign id_ctrl = '{
    wb_en:  id_wb_en,
    mem_rd: id_mem_rd,
    mem_wr: id_mem_wr,
    aluop:  id_aluop,
    sel_a:  id_sel_a,
    sel_b:  id_sel_b
  };

  // Reported unconditionally; the hazard unit decides whether stall/flush override it.
  assign load_use_hazard = vld_p0 & ctrl_p0.mem_rd & (rd_addr_p0 != '0) & id_valid &
                           ((id_rs1_addr == rd_addr_p0) |
                            (id_uses_rs2 & (id_rs2_addr == rd_addr_p0)));

  // ID -> EX register (p0)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_p0      <= 1'b0;
      ctrl_p0     <= '0;
      pc_p0       <= '0;
      imm_p0      <= '0;
      rs1_addr_p0 <= '0;
      rs2_addr_p0 <= '0;
      rd_addr_p0  <= '0;
      rs1_data_p0 <= '0;
      rs2_data_p0 <= '0;
    end else if (flush) begin
      vld_p0  <= 1'b0;
      ctrl_p0 <= CTRL_BUBBLE;
    end else if (stall) begin
      // Capture any bypass seen during the stall so a retiring WB write is not lost.
      rs1_data_p0 <= fwd_rs1;
      rs2_data_p0 <= fwd_rs2;
    end else if (load_use_hazard) begin
      vld_p0  <= 1'b0;
      ctrl_p0 <= CTRL_BUBBLE;
    end else begin
      vld_p0      <= id_valid;
      ctrl_p0     <= id_ctrl;
      pc_p0       <= id_pc;
      imm_p0      <= id_imm;
      rs1_addr_p0 <= id_rs1_addr;
      rs2_addr_p0 <= id_rs2_addr;
      rd_addr_p0  <= id_rd_addr;
      rs1_data_p0 <= id_rs1_data;
      rs2_data_p0 <= id_rs2_data;
    end
  end

  operand_fwd #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs1 (
    .addr     (rs1_addr_p0),
    .reg_data (rs1_data_p0),
    .mem_en   (mem_fwd_en),
    .mem_rd   (mem_fwd_rd),
    .mem_data (mem_fwd_data),
    .wb_en    (wb_fwd_en),
    .wb_rd    (wb_fwd_rd),
    .wb_data  (wb_fwd_data),
    .value    (fwd_rs1)
  );

  operand_fwd #(.XLEN(XLEN), .RA_W(RA_W)) u_fwd_rs2 (
    .addr     (rs2_addr_p0),
    .reg_data (rs2_data_p0),
    .mem_en   (mem_fwd_en),
    .mem_rd   (mem_fwd_rd),
    .mem_data (mem_fwd_data),
    .wb_en    (wb_fwd_en),
    .wb_rd    (wb_fwd_rd),
    .wb_data  (wb_fwd_data),
    .value    (fwd_rs2)
  );

  // EX operand delivery
  assign ex_valid      = vld_p0;
  assign ex_aluop      = ctrl_p0.aluop;
  assign ex_opr_a      = ctrl_p0.sel_a ? pc_p0 : fwd_rs1;
  assign ex_opr_b      = ctrl_p0.sel_b ? imm_p0 : fwd_rs2;
  assign ex_store_data = fwd_rs2;
  assign ex_pc         = pc_p0;
  assign ex_rd_addr    = rd_addr_p0;
  assign ex_wb_en      = vld_p0 & ctrl_p0.wb_en;
  assign ex_mem_rd     = vld_p0 & ctrl_p0.mem_rd;
  assign ex_mem_wr     = vld_p0 & ctrl_p0.mem_wr;

endmodule

// File: tb/tb_id_ex_stage.sv
// Scoreboard bench for id_ex_stage: expected EX contents are queued when ID is
// driven and compared on the following falling edge.
module tb_id_ex_stage;
  import riscv_pkg::*;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  logic            clk = 1'b0;
  logic            rst;
  logic            id_valid;
  logic [XLEN-1:0] id_pc;
  logic [RA_W-1:0] id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [XLEN-1:0] id_rs1_data, id_rs2_data, id_imm;
  logic [3:0]      id_aluop;
  logic            id_sel_a, id_sel_b, id_uses_rs2;
  logic            id_wb_en, id_mem_rd, id_mem_wr;
  logic            stall, flush;
  logic            mem_fwd_en;
  logic [RA_W-1:0] mem_fwd_rd;
  logic [XLEN-1:0] mem_fwd_data;
  logic            wb_fwd_en;
  logic [RA_W-1:0] wb_fwd_rd;
  logic [XLEN-1:0] wb_fwd_data;
  logic            load_use_hazard;
  logic            ex_valid;
  logic [3:0]      ex_aluop;
  logic [XLEN-1:0] ex_opr_a, ex_opr_b, ex_store_data, ex_pc;
  logic [RA_W-1:0] ex_rd_addr;
  logic            ex_wb_en, ex_mem_rd, ex_mem_wr;

  typedef struct packed {
    logic            valid;
    logic [3:0]      aluop;
    logic [XLEN-1:0] opr_a;
    logic [XLEN-1:0] opr_b;
    logic [XLEN-1:0] store;
    logic [XLEN-1:0] pc;
    logic [RA_W-1:0] rd;
    logic            wb;
    logic            mrd;
    logic            mwr;
  } obs_t;

  typedef struct packed {
    obs_t exp;
    obs_t mask;
  } sb_t;

  obs_t obs;
  obs_t m_full;
  obs_t m_ctrl;
  sb_t  sb_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  assign obs = {ex_valid, ex_aluop, ex_opr_a, ex_opr_b, ex_store_data, ex_pc,
                ex_rd_addr, ex_wb_en, ex_mem_rd, ex_mem_wr};

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .RA_W(RA_W)) dut (
    .clk             (clk),
    .rst             (rst),
    .id_valid        (id_valid),
    .id_pc           (id_pc),
    .id_rs1_addr     (id_rs1_addr),
    .id_rs2_addr     (id_rs2_addr),
    .id_rd_addr      (id_rd_addr),
    .id_rs1_data     (id_rs1_data),
    .id_rs2_data     (id_rs2_data),
    .id_imm          (id_imm),
    .id_aluop        (id_aluop),
    .id_sel_a        (id_sel_a),
    .id_sel_b        (id_sel_b),
    .id_uses_rs2     (id_uses_rs2),
    .id_wb_en        (id_wb_en),
    .id_mem_rd       (id_mem_rd),
    .id_mem_wr       (id_mem_wr),
    .stall           (stall),
    .flush           (flush),
    .mem_fwd_en      (mem_fwd_en),
    .mem_fwd_rd      (mem_fwd_rd),
    .mem_fwd_data    (mem_fwd_data),
    .wb_fwd_en       (wb_fwd_en),
    .wb_fwd_rd       (wb_fwd_rd),
    .wb_fwd_data     (wb_fwd_data),
    .load_use_hazard (load_use_hazard),
    .ex_valid        (ex_valid),
    .ex_aluop        (ex_aluop),
    .ex_opr_a        (ex_opr_a),
    .ex_opr_b        (ex_opr_b),
    .ex_store_data   (ex_store_data),
    .ex_pc           (ex_pc),
    .ex_rd_addr      (ex_rd_addr),
    .ex_wb_en        (ex_wb_en),
    .ex_mem_rd       (ex_mem_rd),
    .ex_mem_wr       (ex_mem_wr)
  );

  task automatic idle();
    id_valid = 0; id_pc = '0; id_rs1_addr = '0; id_rs2_addr = '0; id_rd_addr = '0;
    id_rs1_data = '0; id_rs2_data = '0; id_imm = '0; id_aluop = '0;
    id_sel_a = 0; id_sel_b = 0; id_uses_rs2 = 0; id_wb_en = 0; id_mem_rd = 0; id_mem_wr = 0;
    stall = 0; flush = 0;
    mem_fwd_en = 0; mem_fwd_rd = '0; mem_fwd_data = '0;
    wb_fwd_en = 0; wb_fwd_rd = '0; wb_fwd_data = '0;
  endtask

  task automatic set_id(input logic [XLEN-1:0] pc, input logic [RA_W-1:0] rs1,
                        input logic [XLEN-1:0] rs1d, input logic [RA_W-1:0] rs2,
                        input logic [XLEN-1:0] rs2d, input logic [RA_W-1:0] rd,
                        input logic [XLEN-1:0] imm, input logic [3:0] op,
                        input logic sa, input logic sbb, input logic u2,
                        input logic wb, input logic mrd, input logic mwr);
    id_valid = 1; id_pc = pc; id_rs1_addr = rs1; id_rs1_data = rs1d;
    id_rs2_addr = rs2; id_rs2_data = rs2d; id_rd_addr = rd; id_imm = imm;
    id_aluop = op; id_sel_a = sa; id_sel_b = sbb; id_uses_rs2 = u2;
    id_wb_en = wb; id_mem_rd = mrd; id_mem_wr = mwr;
  endtask

  // Reference: what EX must present for an instruction loaded without forwarding.
  function automatic obs_t model(input logic [XLEN-1:0] pc, input logic [XLEN-1:0] rs1d,
                                 input logic [XLEN-1:0] rs2d, input logic [RA_W-1:0] rd,
                                 input logic [XLEN-1:0] imm, input logic [3:0] op,
                                 input logic sa, input logic sbb,
                                 input logic wb, input logic mrd, input logic mwr);
    obs_t e;
    e.valid = 1'b1; e.aluop = op;
    e.opr_a = sa ? pc : rs1d;
    e.opr_b = sbb ? imm : rs2d;
    e.store = rs2d; e.pc = pc; e.rd = rd;
    e.wb = wb; e.mrd = mrd; e.mwr = mwr;
    return e;
  endfunction

  function automatic obs_t bubble();
    obs_t e;
    e = '0;
    e.aluop = ALU_ADD;
    return e;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (2) @(negedge clk);
    total_cnt++;
    if (obs !== obs_t'('0)) $display("FAIL reset got=%h exp=0", obs);
    else pass_cnt++;
    rst = 1'b0;
  endtask

  task automatic test_load();
    sb_t s;
    set_id(32'h100, 5'd1, 32'd5, 5'd2, 32'd7, 5'd3, 32'h0, ALU_ADD, 0, 0, 1, 1, 0, 0);
    sb_q.push_back('{exp: model(32'h100, 32'd5, 32'd7, 5'd3, 32'h0, ALU_ADD, 0, 0, 1, 0, 0),
                     mask: m_full});
    @(negedge clk);
    total_cnt++;
    if (sb_q.size() == 0) $display("FAIL load scoreboard empty");
    else begin
      s = sb_q.pop_front();
      if ((obs & s.mask) !== (s.exp & s.mask))
        $display("FAIL load got=%h exp=%h", obs & s.mask, s.exp & s.mask);
      else pass_cnt++;
    end
    idle();
  endtask

  task automatic test_forward();
    sb_t s;
    set_id(32'h200, 5'd4, 32'h11, 5'd0, 32'h0, 5'd9, 32'h0, ALU_ADD, 0, 0, 0, 1, 0, 0);
    sb_q.push_back('{exp: model(32'h200, 32'h11, 32'h0, 5'd9, 32'h0, ALU_ADD, 0, 0, 1, 0, 0),
                     mask: m_full});
    @(negedge clk);
    total_cnt++;
    if (sb_q.size() == 0) $display("FAIL fwd_load scoreboard empty");
    else begin
      s = sb_q.pop_front();
      if ((obs & s.mask) !== (s.exp & s.mask))
        $display("FAIL fwd_load got=%h exp=%h", obs & s.mask, s.exp & s.mask);
      else pass_cnt++;
    end
    idle();
    mem_fwd_en = 1; mem_fwd_rd = 5'd4; mem_fwd_data = 32'hAA;
    wb_fwd_en = 1;  wb_fwd_rd = 5'd4;  wb_fwd_data = 32'hBB;
    #1;
    total_cnt++;
    if (ex_opr_a !== 32'hAA) $display("FAIL fwd_mem_prio got=%h exp=%h", ex_opr_a, 32'hAA);
    else pass_cnt++;
    mem_fwd_en = 0;
    #1;
    total_cnt++;
    if (ex_opr_a !== 32'hBB) $display("FAIL fwd_wb got=%h exp=%h", ex_opr_a, 32'hBB);
    else pass_cnt++;
    set_id(32'h204, 5'd0, 32'h0, 5'd0, 32'h0, 5'd10, 32'h0, ALU_ADD, 0, 0, 0, 1, 0, 0);
    @(negedge clk);
    idle();
    mem_fwd_en = 1; mem_fwd_rd = 5'd0; mem_fwd_data = 32'hAA;
    wb_fwd_en = 1;  wb_fwd_rd = 5'd0;  wb_fwd_data = 32'hBB;
    #1;
    total_cnt++;
    if (ex_opr_a !== 32'h0) $display("FAIL fwd_x0 got=%h exp=0", ex_opr_a);
    else pass_cnt++;
    idle();
  endtask

  task automatic test_load_use();
    sb_t s;
    set_id(32'h300, 5'd2, 32'h100, 5'd0, 32'h0, 5'd5, 32'h8, ALU_ADD, 0, 1, 0, 1, 1, 0);
    @(negedge clk);
    set_id(32'h304, 5'd5, 32'h3, 5'd1, 32'h55, 5'd6, 32'h0, ALU_ADD, 0, 0, 1, 1, 0, 0);
    #1;
    total_cnt++;
    if (load_use_hazard !== 1'b1) $display("FAIL lu_rs1 got=%b exp=1", load_use_hazard);
    else pass_cnt++;
    id_rs1_addr = 5'd1; id_rs2_addr = 5'd5; id_uses_rs2 = 0;
    #1;
    total_cnt++;
    if (load_use_hazard !== 1'b0) $display("FAIL lu_rs2_unused got=%b exp=0", load_use_hazard);
    else pass_cnt++;
    id_uses_rs2 = 1;
    #1;
    total_cnt++;
    if (load_use_hazard !== 1'b1) $display("FAIL lu_rs2 got=%b exp=1", load_use_hazard);
    else pass_cnt++;
    sb_q.push_back('{exp: bubble(), mask: m_ctrl});
    @(negedge clk);
    total_cnt++;
    if (sb_q.size() == 0) $display("FAIL lu_bubble scoreboard empty");
    else begin
      s = sb_q.pop_front();
      if ((obs & s.mask) !== (s.exp & s.mask))
        $display("FAIL lu_bubble got=%h exp=%h", obs & s.mask, s.exp & s.mask);
      else pass_cnt++;
    end
    #1;
    total_cnt++;
    if (load_use_hazard !== 1'b0) $display("FAIL lu_clear got=%b exp=0", load_use_hazard);
    else pass_cnt++;
    sb_q.push_back('{exp: model(32'h304, 32'h3, 32'h55, 5'd6, 32'h0, ALU_ADD, 0, 0, 1, 0, 0),
                     mask: m_full});
    @(negedge clk);
    total_cnt++;
    if (sb_q.size() == 0) $display("FAIL lu_replay scoreboard empty");
    else begin
      s = sb_q.pop_front();
      if ((obs & s.mask) !== (s.exp & s.mask))
        $display("FAIL lu_replay got=%h exp=%h", obs & s.mask, s.exp & s.mask);
      else pass_cnt++;
    end
    idle();
  endtask

  task automatic test_stall_refresh();
    sb_t s;
    set_id(32'h400, 5'd6, 32'h0, 5'd7, 32'h22, 5'd8, 32'h0, ALU_SUB, 0, 0, 1, 1, 0, 0);
    sb_q.push_back('{exp: model(32'h400, 32'h1234, 32'h22, 5'd8, 32'h0, ALU_SUB, 0, 0, 1, 0, 0),
                     mask: m_full});
    @(negedge clk);
    set_id(32'h500, 5'd9, 32'h99, 5'd9, 32'h99, 5'd9, 32'h9, ALU_XOR, 1, 1, 1, 0, 0, 1);
    stall = 1;
    wb_fwd_en = 1; wb_fwd_rd = 5'd6; wb_fwd_data = 32'h1234;
    @(negedge clk);
    wb_fwd_en = 0; wb_fwd_rd = '0; wb_fwd_data = '0;
    @(negedge clk);
    stall = 0; id_valid = 0;
    #1;
    total_cnt++;
    if (sb_q.size() == 0) $display("FAIL stall_refresh scoreboard empty");
    else begin
      s = sb_q.pop_front();
      if ((obs & s.mask) !== (s.exp & s.mask))
        $display("FAIL stall_refresh got=%h exp=%h", obs & s.mask, s.exp & s.mask);
      else pass_cnt++;
    end
    @(negedge clk);
    idle();
  endtask

  task automatic test_flush();
    sb_t s;
    set_id(32'h600, 5'd1, 32'h1, 5'd2, 32'h2, 5'd3, 32'h0, ALU_OR, 0, 0, 1, 1, 0, 0);
    @(negedge clk);
    set_id(32'h604, 5'd1, 32'h1, 5'd2, 32'h2, 5'd4, 32'h0, ALU_AND, 0, 0, 1, 1, 0, 1);
    flush = 1; stall = 1;
    sb_q.push_back('{exp: bubble(), mask: m_ctrl});
    @(negedge clk);
    total_cnt++;
    if (sb_q.size() == 0) $display("FAIL flush_wins scoreboard empty");
    else begin
      s = sb_q.pop_front();
      if ((obs & s.mask) !== (s.exp & s.mask))
        $display("FAIL flush_wins got=%h exp=%h", obs & s.mask, s.exp & s.mask);
      else pass_cnt++;
    end
    idle();
  endtask

  task automatic test_async_reset();
    set_id(32'h700, 5'd1, 32'h77, 5'd2, 32'h66, 5'd3, 32'h5, ALU_PASS, 1, 1, 1, 1, 0, 1);
    @(negedge clk);
    idle();
    total_cnt++;
    if (ex_valid !== 1'b1) $display("FAIL pre_reset_valid got=%b exp=1", ex_valid);
    else pass_cnt++;
    #2 rst = 1'b1;
    #1;
    total_cnt++;
    if (obs !== obs_t'('0)) $display("FAIL async_reset got=%h exp=0", obs);
    else pass_cnt++;
    #1 rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    sb_t s;
    logic [XLEN-1:0] pc, a, b, imm;
    logic [RA_W-1:0] rd;
    logic [3:0] op;
    logic sa, sbb, wb, mwr;
    for (int i = 0; i < 8; i++) begin
      pc = 32'h800 + 32'(i * 4);
      a = $urandom; b = $urandom; imm = $urandom;
      rd = RA_W'($urandom_range(1, 31));
      op = 4'($urandom); sa = 1'($urandom); sbb = 1'($urandom);
      wb = 1'($urandom); mwr = 1'($urandom);
      set_id(pc, RA_W'($urandom), a, RA_W'($urandom), b, rd, imm, op, sa, sbb, 1, wb, 0, mwr);
      sb_q.push_back('{exp: model(pc, a, b, rd, imm, op, sa, sbb, wb, 0, mwr), mask: m_full});
      @(negedge clk);
      total_cnt++;
      if (sb_q.size() == 0) $display("FAIL b2b[%0d] scoreboard empty", i);
      else begin
        s = sb_q.pop_front();
        if ((obs & s.mask) !== (s.exp & s.mask))
          $display("FAIL b2b[%0d] got=%h exp=%h", i, obs & s.mask, s.exp & s.mask);
        else pass_cnt++;
      end
    end
    idle();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    m_full = '1;
    m_ctrl = '0;
    m_ctrl.valid = 1'b1; m_ctrl.aluop = '1;
    m_ctrl.wb = 1'b1; m_ctrl.mrd = 1'b1; m_ctrl.mwr = 1'b1;
    test_reset();
    test_load();
    test_forward();
    test_load_use();
    test_stall_refresh();
    test_flush();
    test_async_reset();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
